// File: rtl/vx_victim_sel_if.sv
// rtl/vx_victim_sel_if.sv - fill-request / victim-result handshake bundle for vx_victim_sel
// slave is the selector side, master is the requester/consumer side.
interface vx_victim_sel_if #(
    parameter int NUM_WAYS = 4,
    parameter int ID_WIDTH = 8
);
    localparam int WAY_BITS = $clog2(NUM_WAYS);

    logic                req_valid;
    logic                req_ready;
    logic [NUM_WAYS-1:0] req_valid_mask;
    logic [ID_WIDTH-1:0] req_id;

    logic                resp_valid;
    logic                resp_ready;
    logic [WAY_BITS-1:0] resp_way;
    logic                resp_evict;
    logic [ID_WIDTH-1:0] resp_id;

    modport slave (
        input  req_valid,
        input  req_valid_mask,
        input  req_id,
        input  resp_ready,
        output req_ready,
        output resp_valid,
        output resp_way,
        output resp_evict,
        output resp_id
    );

    modport master (
        output req_valid,
        output req_valid_mask,
        output req_id,
        output resp_ready,
        input  req_ready,
        input  resp_valid,
        input  resp_way,
        input  resp_evict,
        input  resp_id
    );
endinterface

// File: rtl/vx_victim_sel.sv
// rtl/vx_victim_sel.sv - cache fill victim selector: first invalid way, else rnd^rr_cnt
// Optional way locking for the random pick is enabled by defining VX_VICTIM_LOCK_EN.
module vx_victim_sel #(
    parameter  int NUM_WAYS = 4,
    parameter  int ID_WIDTH = 8,
    localparam int WAY_BITS = $clog2(NUM_WAYS)
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [WAY_BITS-1:0] rnd,
`ifdef VX_VICTIM_LOCK_EN
    input  logic [NUM_WAYS-1:0] lock_mask,
    output logic                resp_lock_ovr,
`endif
    vx_victim_sel_if.slave      bus
);

    logic                resp_valid_q, resp_valid_d;
    logic [WAY_BITS-1:0] resp_way_q,   resp_way_d;
    logic                resp_evict_q, resp_evict_d;
    logic [ID_WIDTH-1:0] resp_id_q,    resp_id_d;
    logic [WAY_BITS-1:0] rr_cnt_q,     rr_cnt_d;
    logic                lock_ovr_q,   lock_ovr_d;

    logic                accept;
    logic                free_found;
    logic [WAY_BITS-1:0] free_way;
    logic [WAY_BITS-1:0] pick;
    logic [WAY_BITS-1:0] rand_way;
    logic                all_locked;

    assign bus.req_ready = !resp_valid_q || bus.resp_ready;
    assign accept        = bus.req_valid && bus.req_ready;

    // Lowest-index invalid way of the indexed set.
    always_comb begin
        free_found = 1'b0;
        free_way   = '0;
        for (int i = 0; i < NUM_WAYS; i++) begin
            if (!free_found && !bus.req_valid_mask[i]) begin
                free_found = 1'b1;
                free_way   = WAY_BITS'(i);
            end
        end
    end

    // rr_cnt keeps the pick rotating even if the PRNG sticks at one value.
    assign pick = rnd ^ rr_cnt_q;

`ifdef VX_VICTIM_LOCK_EN
    logic                scan_found;
    logic [WAY_BITS-1:0] cand;

    // A locked pick moves to the next unlocked way circularly upward;
    // with every way locked the lock mask is ignored.
    always_comb begin
        all_locked = &lock_mask;
        rand_way   = pick;
        scan_found = 1'b0;
        cand       = pick;
        if (!all_locked && lock_mask[pick]) begin
            for (int k = 1; k < NUM_WAYS; k++) begin
                cand = pick + WAY_BITS'(k);
                if (!scan_found && !lock_mask[cand]) begin
                    scan_found = 1'b1;
                    rand_way   = cand;
                end
            end
        end
    end

    assign resp_lock_ovr = lock_ovr_q;
`else
    assign all_locked = 1'b0;
    assign rand_way   = pick;
`endif

    always_comb begin
        resp_valid_d = resp_valid_q;
        resp_way_d   = resp_way_q;
        resp_evict_d = resp_evict_q;
        resp_id_d    = resp_id_q;
        rr_cnt_d     = rr_cnt_q;
        lock_ovr_d   = lock_ovr_q;
        if (accept) begin
            resp_valid_d = 1'b1;
            resp_id_d    = bus.req_id;
            if (free_found) begin
                resp_way_d   = free_way;
                resp_evict_d = 1'b0;
                lock_ovr_d   = 1'b0;
            end else begin
                resp_way_d   = rand_way;
                resp_evict_d = 1'b1;
                lock_ovr_d   = all_locked;
                rr_cnt_d     = rr_cnt_q + WAY_BITS'(1);
            end
        end else if (bus.resp_ready) begin
            resp_valid_d = 1'b0;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            resp_valid_q <= 1'b0;
            resp_way_q   <= '0;
            resp_evict_q <= 1'b0;
            resp_id_q    <= '0;
            rr_cnt_q     <= '0;
            lock_ovr_q   <= 1'b0;
        end else begin
            resp_valid_q <= resp_valid_d;
            resp_way_q   <= resp_way_d;
            resp_evict_q <= resp_evict_d;
            resp_id_q    <= resp_id_d;
            rr_cnt_q     <= rr_cnt_d;
            lock_ovr_q   <= lock_ovr_d;
        end
    end

    assign bus.resp_valid = resp_valid_q;
    assign bus.resp_way   = resp_way_q;
    assign bus.resp_evict = resp_evict_q;
    assign bus.resp_id    = resp_id_q;

endmodule

// File: tb/tb_vx_victim_sel.sv
// tb/tb_vx_victim_sel.sv - self-checking bench for vx_victim_sel
// Directed vector table, hand-written stall/reset sequences, then randomized traffic vs a model.
module tb_vx_victim_sel;
    localparam int N  = 4;
    localparam int IW = 8;
    localparam int WB = 2;

    logic          clk;
    logic          reset;
    logic [WB-1:0] rnd;
    logic [N-1:0]  lock_mask;
`ifdef VX_VICTIM_LOCK_EN
    logic          resp_lock_ovr;
`endif

    vx_victim_sel_if #(.NUM_WAYS(N), .ID_WIDTH(IW)) vif ();

    vx_victim_sel #(.NUM_WAYS(N), .ID_WIDTH(IW)) dut (
        .clk           (clk),
        .reset         (reset),
        .rnd           (rnd),
`ifdef VX_VICTIM_LOCK_EN
        .lock_mask     (lock_mask),
        .resp_lock_ovr (resp_lock_ovr),
`endif
        .bus           (vif.slave)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    int tests  = 0;
    int failed = 0;

    bit m_valid, m_evict, m_ovr;
    int m_way, m_id, m_rr;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        tests++;
        if (act !== exp) begin
            failed++;
            $display("FAIL %s: got %0d expected %0d at %0t", name, act, exp, $time);
        end
    endtask

    // Reference victim choice from the selection rules, on plain ints.
    task automatic mvictim(input logic [N-1:0] mask, input logic [N-1:0] lock, input int r, input int rr,
                           output int way, output bit ev, output bit ovr);
        bit found = 0;
        way = 0; ev = 0; ovr = 0;
        for (int i = 0; i < N; i++)
            if (!found && mask[i] == 1'b0) begin found = 1; way = i; end
        if (!found) begin
            int p;
            ev = 1;
            p  = (r ^ rr) % N;
            way = p;
            if (lock == {N{1'b1}}) ovr = 1;
            else if (lock[p]) begin
                bit got = 0;
                for (int k = 1; k < N; k++)
                    if (!got && !lock[(p + k) % N]) begin got = 1; way = (p + k) % N; end
            end
        end
    endtask

    // One clock: check req_ready before the edge, advance the model, check outputs after it.
    task automatic cycle();
        bit acc, ev, ov;
        int w, id_s;
        logic [N-1:0] lk;
        #1;
        check("req_ready", vif.req_ready, !m_valid || vif.resp_ready);
`ifdef VX_VICTIM_LOCK_EN
        lk = lock_mask;
`else
        lk = '0;
`endif
        acc  = vif.req_valid && (!m_valid || vif.resp_ready);
        id_s = vif.req_id;
        w = 0; ev = 0; ov = 0;
        if (acc) mvictim(vif.req_valid_mask, lk, rnd, m_rr, w, ev, ov);
        @(posedge clk);
        #1;
        if (reset) begin
            m_valid = 0; m_way = 0; m_evict = 0; m_id = 0; m_rr = 0; m_ovr = 0;
        end else if (acc) begin
            m_valid = 1; m_way = w; m_evict = ev; m_ovr = ov; m_id = id_s;
            if (ev) m_rr = (m_rr + 1) % N;
        end else if (vif.resp_ready) begin
            m_valid = 0;
        end
        check("resp_valid", vif.resp_valid, m_valid);
        check("resp_way",   vif.resp_way,   m_way);
        check("resp_evict", vif.resp_evict, m_evict);
        check("resp_id",    vif.resp_id,    m_id);
`ifdef VX_VICTIM_LOCK_EN
        check("resp_lock_ovr", resp_lock_ovr, m_ovr);
`endif
    endtask

    task automatic drive(input bit v, input logic [N-1:0] mask, input logic [WB-1:0] r,
                         input logic [IW-1:0] id, input bit rdy);
        vif.req_valid      = v;
        vif.req_valid_mask = mask;
        rnd                = r;
        vif.req_id         = id;
        vif.resp_ready     = rdy;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        drive(0, '0, '0, '0, 1);
        cycle();
        reset = 1'b0;
    endtask

    typedef struct {
        logic [N-1:0]  mask;
        logic [WB-1:0] r;
        logic [IW-1:0] id;
        int            way;
        bit            evict;
    } vec_t;

    vec_t vt[8];

    initial begin
        #500000;
        $display("FAIL timeout: simulation did not finish");
        $fatal(1, "timeout");
    end

    initial begin
        lock_mask = '0;
        reset     = 1'b1;
        drive(0, '0, '0, '0, 1);
        m_valid = 0; m_way = 0; m_evict = 0; m_id = 0; m_rr = 0; m_ovr = 0;
        repeat (2) @(posedge clk);
        #1;
        reset = 1'b0;
        check("rst_resp_valid", vif.resp_valid, 0);
        check("rst_resp_way",   vif.resp_way,   0);
        check("rst_resp_evict", vif.resp_evict, 0);
        check("rst_resp_id",    vif.resp_id,    0);

        // Back-to-back accepted requests, one result per cycle.
        vt[0] = '{4'b1011, 2'b00, 8'h11, 2, 0};
        vt[1] = '{4'b1111, 2'b01, 8'h21, 1, 1};
        vt[2] = '{4'b1111, 2'b01, 8'h22, 0, 1};
        vt[3] = '{4'b1111, 2'b01, 8'h23, 3, 1};
        vt[4] = '{4'b0000, 2'b11, 8'h24, 0, 0};
        vt[5] = '{4'b0111, 2'b10, 8'h25, 3, 0};
        vt[6] = '{4'b1111, 2'b00, 8'h26, 3, 1};
        vt[7] = '{4'b1111, 2'b10, 8'h27, 2, 1};
        for (int i = 0; i < 8; i++) begin
            drive(1, vt[i].mask, vt[i].r, vt[i].id, 1);
            cycle();
            check("vec_valid", vif.resp_valid, 1);
            check("vec_way",   vif.resp_way,   vt[i].way);
            check("vec_evict", vif.resp_evict, vt[i].evict);
            check("vec_id",    vif.resp_id,    vt[i].id);
        end

        // Backpressure: result held, no accepts, rr_cnt frozen.
        do_reset();
        drive(1, 4'b1111, 2'b01, 8'h31, 1);
        cycle();
        check("bp_first_way", vif.resp_way, 1);
        for (int k = 0; k < 3; k++) begin
            drive(1, 4'b1111, WB'(k + 2), 8'h32, 0);
            #1;
            check("bp_req_ready", vif.req_ready, 0);
            cycle();
            check("bp_hold_way", vif.resp_way, 1);
            check("bp_hold_id",  vif.resp_id,  8'h31);
        end
        drive(1, 4'b1111, 2'b00, 8'h32, 1);
        cycle();
        check("bp_release_way", vif.resp_way, 1);
        check("bp_release_id",  vif.resp_id,  8'h32);
        drive(1, 4'b1111, 2'b00, 8'h33, 1);
        cycle();
        check("bp_rr_way", vif.resp_way, 2);

        // Reset while a result is stalled drops it and clears rr_cnt.
        do_reset();
        drive(1, 4'b1111, 2'b11, 8'h41, 1);
        cycle();
        drive(0, 4'b1111, 2'b00, 8'h42, 0);
        cycle();
        check("rs_pending", vif.resp_valid, 1);
        reset = 1'b1;
        cycle();
        reset = 1'b0;
        check("rs_valid", vif.resp_valid, 0);
        check("rs_way",   vif.resp_way,   0);
        check("rs_id",    vif.resp_id,    0);
        drive(1, 4'b1111, 2'b10, 8'h43, 1);
        cycle();
        check("rs_after_way", vif.resp_way, 2);

`ifdef VX_VICTIM_LOCK_EN
        do_reset();
        lock_mask = 4'b0110;
        drive(1, 4'b1111, 2'b01, 8'h51, 1);
        cycle();
        check("lk_skip_way", vif.resp_way, 3);
        check("lk_skip_ovr", resp_lock_ovr, 0);
        do_reset();
        lock_mask = 4'b1111;
        drive(1, 4'b1111, 2'b01, 8'h52, 1);
        cycle();
        check("lk_all_way", vif.resp_way, 1);
        check("lk_all_ovr", resp_lock_ovr, 1);
        do_reset();
        lock_mask = 4'b0010;
        drive(1, 4'b1101, 2'b00, 8'h53, 1);
        cycle();
        check("lk_inv_way",   vif.resp_way,   1);
        check("lk_inv_evict", vif.resp_evict, 0);
        lock_mask = '0;
`endif

        // Randomized traffic against the model.
        do_reset();
        for (int n = 0; n < 3000; n++) begin
            reset = ($urandom_range(0, 99) == 0);
            drive($urandom_range(0, 3) != 0,
                  ($urandom_range(0, 1) == 1) ? 4'b1111 : N'($urandom),
                  WB'($urandom), IW'($urandom),
                  $urandom_range(0, 2) != 0);
`ifdef VX_VICTIM_LOCK_EN
            lock_mask = N'($urandom);
`endif
            cycle();
        end
        reset = 1'b0;

        $display("[TB] %0d tests run, %0d failed", tests, failed);
        $finish;
    end
endmodule

// File: doc/vx_victim_sel.md
Name: vx_victim_sel

Overview:
- Cache fill-path victim selector. Sits directly downstream of the cache LFSR random-bit generator and consumes its per-cycle random bits.
- For each miss-fill request it picks the way to replace. The first invalid way wins; if all ways are valid, a pseudo-random way is chosen.
- The result goes to the tag/data write stage through a registered valid/ready interface.

Parameters:
- NUM_WAYS, 4, associativity. Must be a power of two, >= 2.
- WAY_BITS, $clog2(NUM_WAYS), width of the way index (derived; do not override).
- ID_WIDTH, 8, width of the request tag passed through unchanged.

Ports:
- clk  in  1  clock
- reset  in  1  synchronous, active-high reset
- rnd  in  WAY_BITS  random bits from the PRNG stage, new value every cycle
- req_valid  in  1  fill request present
- req_ready  out  1  request accepted this cycle when req_valid && req_ready
- req_valid_mask  in  NUM_WAYS  per-way line-valid bits of the indexed set
- req_id  in  ID_WIDTH  request tag
- resp_valid  out  1  victim result present
- resp_ready  in  1  downstream accepts result
- resp_way  out  WAY_BITS  selected victim way
- resp_evict  out  1  1 = victim holds a valid line (writeback/evict check needed); 0 = invalid way filled
- resp_id  out  ID_WIDTH  tag of the request

Behaviour:
- **Reset values:** resp_valid=0, resp_way=0, resp_evict=0, resp_id=0, internal rr_cnt=0. Reset has priority over all other activity; an in-flight result is dropped.
- **Handshake:** single output register.
  - req_ready = !resp_valid || resp_ready (combinational).
  - A result is held stable while resp_valid && !resp_ready.
  - Latency is 1 cycle: a request accepted at edge N gives resp_valid at N+1.
  - Accept and drain in the same cycle are allowed, giving full throughput of 1 request/cycle.
- **Selection, computed combinationally on the request side and registered at accept:**
  - If any bit of req_valid_mask is 0: victim = lowest-index 0 bit, evict=0, and rr_cnt is unchanged.
  - If the mask is all ones: victim = rnd XOR rr_cnt (WAY_BITS wide, wraps naturally), evict=1, and rr_cnt increments mod NUM_WAYS.
  - The rr_cnt term guarantees rotation even if the PRNG stalls at a constant value.
- rnd is sampled only on the accepting edge. rnd values in non-accepting cycles have no effect.
- rr_cnt changes only on accepted all-valid requests. Stalled cycles never advance it.
- req_valid_mask and req_id are don't-care when req_valid=0.
- No X propagation: with req_valid=0, the output registers hold their values.

Optional Feature:
- Macro: VX_VICTIM_LOCK_EN.
- **When defined:** adds input lock_mask [NUM_WAYS-1:0], sampled with the request.
  - Locked ways are excluded from random selection only. An invalid locked way may still be filled.
  - If the random pick p = rnd XOR rr_cnt is locked, choose the first unlocked way scanning circularly upward from p+1.
  - If all ways are locked, the lock mask is ignored and p is used.
  - Adds output resp_lock_ovr (1 = all-locked override occurred; reset 0).
- **When undefined:** no lock_mask or resp_lock_ovr ports; behaviour exactly as above.

Test Plan:
1. Reset, then NUM_WAYS=4, mask=4'b1011, id=0x11, resp_ready=1 -> next cycle resp_valid=1, way=2, evict=0, id=0x11; rr_cnt remains 0.
2. Mask=4'b1111, rnd=2'b01 on three consecutive accepted cycles, resp_ready=1 -> ways 1,0,3 (rr_cnt 0,1,2), evict=1 each; full throughput, req_ready stays 1.
3. Backpressure: result pending, resp_ready=0 for 3 cycles while req_valid=1 and rnd toggles -> req_ready=0, resp_way/resp_id stable, rr_cnt unchanged; after resp_ready=1 the next request is accepted the same cycle.
4. Reset asserted while resp_valid=1 and resp_ready=0 -> next cycle resp_valid=0, outputs 0; the following all-valid request with rnd=2'b10 yields way=2 (rr_cnt back to 0).
5. VX_VICTIM_LOCK_EN, mask=4'b1111, lock=4'b0110, rnd=2'b01, rr_cnt=0 -> way=3, resp_lock_ovr=0; lock=4'b1111 -> way=1, resp_lock_ovr=1.
6. VX_VICTIM_LOCK_EN, mask=4'b1101, lock=4'b0010 -> way=1 (invalid way wins despite lock), evict=0.
